lpc_host: RTL
=============

LPC_HOST -- requirements
Module: lpc_host

Interface
REQ-001 The module SHALL have parameter SYNC_TIMEOUT, default 8, giving the number of non-terminal SYNC cycles before abort (range 2..255).
REQ-002 The module SHALL have port clk_i, input, 1 bit: the LPC clock (LCLK); it is the only clock.
REQ-003 The module SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port lframe_o, output, 1 bit: LFRAME#, active low.
REQ-005 The module SHALL have port lad_o, output, 4 bits: LAD drive value.
REQ-006 The module SHALL have port lad_oe_o, output, 1 bit: LAD output enable (1 = host drives).
REQ-007 The module SHALL have port lad_i, input, 4 bits: sampled LAD.
REQ-008 The module SHALL have port req_i, input, 1 bit: cycle request, sampled only in IDLE.
REQ-009 The module SHALL have port req_wr_i, input, 1 bit: 1 = I/O write, 0 = I/O read.
REQ-010 The module SHALL have port req_addr_i, input, 16 bits: I/O address.
REQ-011 The module SHALL have port req_data_i, input, 8 bits: write data.
REQ-012 The module SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The module SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-014 The module SHALL have port rd_data_o, output, 8 bits: read data, valid when done_o is high on a read.
REQ-015 The module SHALL have port err_o, output, 1 bit: qualifies done_o; 1 = SYNC error or abort.

Function
REQ-016 All outputs SHALL be registered on the rising edge of clk_i.
REQ-017 In IDLE, req_i=1 SHALL latch req_wr_i, req_addr_i and req_data_i, and START SHALL begin on the next cycle; req_i while busy_o is high SHALL be ignored.
REQ-018 The states SHALL be IDLE, START, CYCDIR, ADDR (4 cycles), WDATA (2), TAR1, TAR2, SYNC, RDATA (2), PTAR1, PTAR2 and ABORT.
REQ-019 The write sequence SHALL be START, CYCDIR, ADDR, WDATA, TAR1, TAR2, SYNC, PTAR1, PTAR2.
REQ-020 The read sequence SHALL be START, CYCDIR, ADDR, TAR1, TAR2, SYNC, RDATA, PTAR1, PTAR2.
REQ-021 In START, lframe_o SHALL be 0 and lad_o SHALL be 0000; lframe_o SHALL be 1 in every other state except ABORT.
REQ-022 CYCDIR SHALL drive 0000 for a read and 0010 for a write.
REQ-023 ADDR SHALL drive address nibbles MSB first ([15:12] .. [3:0]); WDATA SHALL drive [3:0] then [7:4].
REQ-024 TAR1 SHALL drive 1111 with lad_oe_o=1; lad_oe_o SHALL be 0 from TAR2 through PTAR2.
REQ-025 In SYNC, lad_i=0000 (READY) SHALL advance the state; 1010 (ERROR) SHALL advance and set a sticky error flag; 0101 and 0110 (short and long wait) and any other value SHALL remain in SYNC.
REQ-026 RDATA SHALL capture lad_i into rd_data_o[3:0] on the first cycle and into [7:4] on the second.
REQ-027 At the end of PTAR2, the state SHALL return to IDLE and done_o SHALL pulse on that cycle, with err_o equal to the sticky error flag.
REQ-028 Minimum latency from the req_i sample to done_o SHALL be 13 cycles for both reads and writes (one SYNC cycle).
REQ-029 The next request SHALL be accepted no earlier than the cycle after done_o.

Reset
REQ-030 While rst_i=1 at a clock edge, the state SHALL become IDLE, lframe_o=1, lad_oe_o=0, lad_o=1111, busy_o=0, done_o=0, err_o=0, rd_data_o=00, and the counters and sticky error flag SHALL be cleared.
REQ-031 Reset asserted mid-cycle (any state) SHALL abandon the transaction without pulsing done_o.
REQ-032 Reset SHALL take priority over req_i.

Configuration
REQ-033 With macro LPC_HOST_SYNC_TIMEOUT_EN defined, each SYNC cycle that is not READY or ERROR SHALL increment a counter.
REQ-034 With LPC_HOST_SYNC_TIMEOUT_EN defined, when the counter reaches SYNC_TIMEOUT the state SHALL enter ABORT.
REQ-035 ABORT SHALL hold lframe_o=0, lad_oe_o=1 and lad_o=1111 for 4 cycles, then return to IDLE with done_o=1 and err_o=1, and rd_data_o SHALL be left unchanged.
REQ-036 Without LPC_HOST_SYNC_TIMEOUT_EN, SYNC SHALL wait indefinitely, no counter or ABORT state SHALL exist, and err_o SHALL be driven only by SYNC ERROR.

Verification
REQ-037 The bench SHALL issue a write of 0x5A to 0x0C00 with the peripheral returning READY on the first SYNC cycle, and SHALL check LAD 0000,0010,0,C,0,0,A,5,F then done_o at cycle 13 with err_o=0.
REQ-038 The bench SHALL issue a read of 0x0004 with the peripheral returning 0110 twice, then 0000, then data nibbles 3 and 7, and SHALL check rd_data_o=0x73 and done_o at cycle 15.
REQ-039 The bench SHALL return SYNC=1010 on a read, and SHALL check that the RDATA/PTAR phases still complete and done_o=1 with err_o=1.
REQ-040 With LPC_HOST_SYNC_TIMEOUT_EN and SYNC_TIMEOUT=8, the bench SHALL hold LAD at 0110, and SHALL check 8 SYNC cycles, then lframe_o low for 4 cycles with LAD=1111, then done_o=1 and err_o=1.
REQ-041 The bench SHALL assert rst_i during ADDR, and SHALL check lframe_o=1, lad_oe_o=0, busy_o=0 the next cycle and that no done_o pulse occurs.
REQ-042 The bench SHALL pulse req_i while busy_o=1, and SHALL check that the pulse is ignored and only one transaction occurs.

Source files
------------

// File: rtl/lpc_host.sv
// LPC host for single-byte I/O read/write cycles, all outputs registered on LCLK.
// Define LPC_HOST_SYNC_TIMEOUT_EN to abort a cycle after SYNC_TIMEOUT wait SYNCs.
module lpc_host #(
    parameter int unsigned SYNC_TIMEOUT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        lframe_o,
    output logic [3:0]  lad_o,
    output logic        lad_oe_o,
    input  logic [3:0]  lad_i,
    input  logic        req_i,
    input  logic        req_wr_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  rd_data_o,
    output logic        err_o
);

    if (SYNC_TIMEOUT < 2 || SYNC_TIMEOUT > 255) begin : g_param_check
        $error("SYNC_TIMEOUT must lie in 2..255");
    end

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StCycDir,
        StAddr,
        StWData,
        StTar1,
        StTar2,
        StSync,
        StRData,
        StPTar1,
        StPTar2
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
        , StAbort
`endif
    } state_e;

    localparam logic [3:0] SyncReady = 4'b0000;
    localparam logic [3:0] SyncError = 4'b1010;

    state_e      state_q, state_d;
    logic [1:0]  nib_q, nib_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        err_flag_q, err_flag_d;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
    logic [7:0]  sync_cnt_q, sync_cnt_d;
`endif

    logic        lframe_q, lframe_d;
    logic [3:0]  lad_q, lad_d;
    logic        lad_oe_q, lad_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  rd_data_q, rd_data_d;

    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_flag_d = err_flag_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
        sync_cnt_d = sync_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_i) begin
                    wr_d       = req_wr_i;
                    addr_d     = req_addr_i;
                    data_d     = req_data_i;
                    err_flag_d = 1'b0;
                    nib_d      = 2'd0;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
                    sync_cnt_d = 8'd0;
`endif
                    state_d    = StStart;
                end
            end
            StStart:  state_d = StCycDir;
            StCycDir: begin
                nib_d   = 2'd0;
                state_d = StAddr;
            end
            StAddr: begin
                if (nib_q == 2'd3) begin
                    nib_d   = 2'd0;
                    state_d = wr_q ? StWData : StTar1;
                end else begin
                    nib_d = nib_q + 2'd1;
                end
            end
            StWData: begin
                if (nib_q == 2'd1) begin
                    nib_d   = 2'd0;
                    state_d = StTar1;
                end else begin
                    nib_d = nib_q + 2'd1;
                end
            end
            StTar1: state_d = StTar2;
            StTar2: state_d = StSync;
            StSync: begin
                case (lad_i)
                    SyncReady: begin
                        nib_d   = 2'd0;
                        state_d = wr_q ? StPTar1 : StRData;
                    end
                    SyncError: begin
                        nib_d      = 2'd0;
                        err_flag_d = 1'b1;
                        state_d    = wr_q ? StPTar1 : StRData;
                    end
                    default: begin
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
                        // Every wait-class SYNC counts toward the abort limit
                        sync_cnt_d = sync_cnt_q + 8'd1;
                        if (sync_cnt_q == 8'(SYNC_TIMEOUT - 1)) begin
                            nib_d   = 2'd0;
                            state_d = StAbort;
                        end
`endif
                    end
                endcase
            end
            StRData: begin
                if (nib_q == 2'd0) begin
                    rd_data_d[3:0] = lad_i;
                    nib_d          = 2'd1;
                end else begin
                    rd_data_d[7:4] = lad_i;
                    nib_d          = 2'd0;
                    state_d        = StPTar1;
                end
            end
            StPTar1: state_d = StPTar2;
            StPTar2: begin
                done_d  = 1'b1;
                err_d   = err_flag_q;
                state_d = StIdle;
            end
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
            StAbort: begin
                if (nib_q == 2'd3) begin
                    nib_d   = 2'd0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    nib_d = nib_q + 2'd1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs are decoded from the next state so they line up with it once registered
    always_comb begin
        lframe_d = 1'b1;
        lad_d    = 4'hF;
        lad_oe_d = 1'b0;
        busy_d   = (state_d != StIdle);
        case (state_d)
            StStart: begin
                lframe_d = 1'b0;
                lad_d    = 4'h0;
                lad_oe_d = 1'b1;
            end
            StCycDir: begin
                lad_d    = wr_d ? 4'h2 : 4'h0;
                lad_oe_d = 1'b1;
            end
            StAddr: begin
                lad_oe_d = 1'b1;
                case (nib_d)
                    2'd0:    lad_d = addr_d[15:12];
                    2'd1:    lad_d = addr_d[11:8];
                    2'd2:    lad_d = addr_d[7:4];
                    default: lad_d = addr_d[3:0];
                endcase
            end
            StWData: begin
                lad_oe_d = 1'b1;
                lad_d    = (nib_d == 2'd0) ? data_d[3:0] : data_d[7:4];
            end
            StTar1: lad_oe_d = 1'b1;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
            StAbort: begin
                lframe_d = 1'b0;
                lad_oe_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            nib_q      <= 2'd0;
            wr_q       <= 1'b0;
            addr_q     <= 16'h0000;
            data_q     <= 8'h00;
            err_flag_q <= 1'b0;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
            sync_cnt_q <= 8'd0;
`endif
            lframe_q   <= 1'b1;
            lad_q      <= 4'hF;
            lad_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            nib_q      <= nib_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_flag_q <= err_flag_d;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
            sync_cnt_q <= sync_cnt_d;
`endif
            lframe_q   <= lframe_d;
            lad_q      <= lad_d;
            lad_oe_q   <= lad_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign lframe_o  = lframe_q;
    assign lad_o     = lad_q;
    assign lad_oe_o  = lad_oe_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign rd_data_o = rd_data_q;

endmodule
